// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE_array job sequencer: default sizing
// constants, the sequencer state encoding and the job depth helper.
package pe_array_pkg;

   localparam int DEF_ROW_LENGTH = 7;
   localparam int DEF_O_CH       = 3;
   localparam int DEF_K          = 1;
   localparam int DEF_WIDTH      = 14;
   localparam int DEF_DATA_W     = 27;
   localparam int DEF_DRAIN_LAT  = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_CLEAR   = 3'd2,
      ST_STREAM  = 3'd3,
      ST_WAIT    = 3'd4,
      ST_COLLECT = 3'd5,
      ST_DRAIN   = 3'd6
   } state_e;

   // One job holds, per PE column and run, one activation plus O_CH weights.
   function automatic int calc_depth(input int row_length, input int o_ch, input int k);
      return (o_ch + 1) * row_length * k;
   endfunction

endpackage

// File: rtl/pe_array_seq_job_buf.sv
// Job word buffer: DEPTH x DATA_W register file, one write port and one
// combinational read port. Filled during FILL, read out during STREAM.
module seq_job_buf #(
   parameter int DEPTH  = 28,
   parameter int DATA_W = 27,
   parameter int AW     = 5
) (
   input  logic              clk_in,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port: contents are never reset, a job always overwrites every entry.
   always_ff @(posedge clk_in) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_array_seq.sv
// Job sequencer in front of PE_array. Buffers a full job from the upstream
// stream, clears the array, streams the job gaplessly, captures the O_CH
// partial sums at fixed latency and hands them downstream over valid/ready.
// Optional build macro PE_SEQ_PERF_EN adds perf_cycles_out, a saturating
// count of busy cycles for the current/last job.
module pe_array_seq
   import pe_array_pkg::*;
#(
   parameter int ROW_LENGTH = DEF_ROW_LENGTH,
   parameter int O_CH       = DEF_O_CH,
   parameter int K          = DEF_K,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DRAIN_LAT  = DEF_DRAIN_LAT
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   output logic              busy_out,
   output logic              done_out,
   input  logic              src_valid_in,
   input  logic [DATA_W-1:0] src_data_in,
   output logic              src_ready_out,
   output logic [DATA_W-1:0] pe_data_out,
   output logic              pe_rst_out,
   input  logic [WIDTH-1:0]  pe_psum_in,
   output logic              psum_valid_out,
   output logic [WIDTH-1:0]  psum_data_out,
   input  logic              psum_ready_in
`ifdef PE_SEQ_PERF_EN
  ,output logic [15:0]       perf_cycles_out
`endif
);

   localparam int DEPTH = calc_depth(ROW_LENGTH, O_CH, K);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W = (O_CH > 1) ? $clog2(O_CH) : 1;
   localparam int CNT_W = 8;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(O_CH - 1);

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] pe_data_q, pe_data_d;
   logic [WIDTH-1:0]  res_q [O_CH];
   logic              src_fire;
   logic [PTR_W-1:0]  buf_raddr;
   logic [DATA_W-1:0] buf_rdata;

   assign src_fire = (state_q == ST_FILL) && src_valid_in;

   // The read address runs one word ahead of pe_data_out so the output can
   // be registered without a bubble: CLEAR preloads word 0.
   assign buf_raddr = (state_q == ST_STREAM && rd_ptr_q != LAST_PTR) ?
                      rd_ptr_q + PTR_W'(1) : '0;

   seq_job_buf #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (PTR_W)
   ) u_buf (
      .clk_in  (clk_in),
      .we_i    (src_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (src_data_in),
      .raddr_i (buf_raddr),
      .rdata_o (buf_rdata)
   );

   // Next-state, pointer and counter logic for the job sequence.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      pe_data_d = pe_data_q;
      case (state_q)
         ST_IDLE: begin
            // done_q blocks a start held over from the previous job's done cycle
            if (start_in && !done_q) begin
               state_d  = ST_FILL;
               wr_ptr_d = '0;
            end
         end
         ST_FILL: begin
            if (src_valid_in) begin
               if (wr_ptr_q == LAST_PTR) state_d = ST_CLEAR;
               else                      wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
         end
         ST_CLEAR: begin
            state_d   = ST_STREAM;
            rd_ptr_d  = '0;
            pe_data_d = buf_rdata;
         end
         ST_STREAM: begin
            if (rd_ptr_q == LAST_PTR) begin
               state_d = (DRAIN_LAT > 1) ? ST_WAIT : ST_COLLECT;
               cnt_d   = '0;
            end else begin
               rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               pe_data_d = buf_rdata;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(DRAIN_LAT - 2)) begin
               state_d = ST_COLLECT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_COLLECT: begin
            if (cnt_q == CNT_W'(O_CH - 1)) begin
               state_d = ST_DRAIN;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (psum_ready_in) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state and the registered PE data word.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         pe_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         pe_data_q <= pe_data_d;
      end
   end

   // PE_array cannot stall, so psums are captured unconditionally in COLLECT.
   always_ff @(posedge clk_in) begin
      if (state_q == ST_COLLECT) res_q[cnt_q[IDX_W-1:0]] <= pe_psum_in;
   end

   assign busy_out       = (state_q != ST_IDLE);
   assign done_out       = done_q;
   assign src_ready_out  = (state_q == ST_FILL);
   assign pe_data_out    = pe_data_q;
   assign pe_rst_out     = (state_q == ST_STREAM) || (state_q == ST_WAIT) ||
                           (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
   assign psum_valid_out = (state_q == ST_DRAIN);
   assign psum_data_out  = (state_q == ST_DRAIN) ? res_q[idx_q] : '0;

`ifdef PE_SEQ_PERF_EN
   logic [15:0] perf_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Busy-cycle counter: restarts when a job is accepted, holds in IDLE.
   always_ff @(posedge clk_in) begin
      if (rst_in)                                       perf_q <= '0;
      else if (state_q == ST_IDLE && start_in && !done_q) perf_q <= '0;
      else if (state_q != ST_IDLE)                      perf_q <= sat_inc16(perf_q);
   end

   assign perf_cycles_out = perf_q;
`else
   // No busy-cycle counter in this build.
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// Self-checking bench for pe_array_seq with a behavioural PE_array stand-in.
// Build with PE_SEQ_PERF_EN defined to also check perf_cycles_out.
module tb_pe_array_seq;
   import pe_array_pkg::*;

   localparam int ROW_LENGTH = DEF_ROW_LENGTH;
   localparam int O_CH       = DEF_O_CH;
   localparam int K          = DEF_K;
   localparam int WIDTH      = DEF_WIDTH;
   localparam int DATA_W     = DEF_DATA_W;
   localparam int DRAIN_LAT  = DEF_DRAIN_LAT;
   localparam int DEPTH      = (O_CH + 1) * ROW_LENGTH * K;

   logic              clk = 1'b0;
   logic              rst_in = 1'b1;
   logic              start_in = 1'b0;
   logic              busy_out, done_out;
   logic              src_valid_in = 1'b0;
   logic [DATA_W-1:0] src_data_in = '0;
   logic              src_ready_out;
   logic [DATA_W-1:0] pe_data_out;
   logic              pe_rst_out;
   logic [WIDTH-1:0]  pe_psum_in = '0;
   logic              psum_valid_out;
   logic [WIDTH-1:0]  psum_data_out;
   logic              psum_ready_in = 1'b1;
`ifdef PE_SEQ_PERF_EN
   logic [15:0]       perf_cycles_out;
`endif

   always #5 clk = ~clk;

   pe_array_seq dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .start_in       (start_in),
      .busy_out       (busy_out),
      .done_out       (done_out),
      .src_valid_in   (src_valid_in),
      .src_data_in    (src_data_in),
      .src_ready_out  (src_ready_out),
      .pe_data_out    (pe_data_out),
      .pe_rst_out     (pe_rst_out),
      .pe_psum_in     (pe_psum_in),
      .psum_valid_out (psum_valid_out),
      .psum_data_out  (psum_data_out),
      .psum_ready_in  (psum_ready_in)
`ifdef PE_SEQ_PERF_EN
     ,.perf_cycles_out(perf_cycles_out)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference PE_array behaviour: the job is ROW_LENGTH*K columns of
   // {activation, weight row0 .. weight row O_CH-1}; row r psum is the dot
   // product of activations and row-r weights (low 12 bits), modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] psum_of(input logic [DATA_W-1:0] w[$], input int r);
      int acc = 0;
      for (int c = 0; c < ROW_LENGTH * K; c++)
         acc += int'(w[c*(O_CH+1)][11:0]) * int'(w[c*(O_CH+1)+1+r][11:0]);
      return WIDTH'(acc);
   endfunction

   // PE_array stand-in plus cycle statistics, evaluated mid-cycle.
   logic [DATA_W-1:0] cap[$];
   logic [DATA_W-1:0] last_stream[$];
   int post_cnt = 0;
   int busy_cyc = 0, fill_cyc = 0, clear_cyc = 0;
   always @(negedge clk) begin
      if (busy_out === 1'b1) busy_cyc++;
      if (src_ready_out === 1'b1) fill_cyc++;
      if (busy_out === 1'b1 && src_ready_out === 1'b0 && pe_rst_out === 1'b0) clear_cyc++;
      if (pe_rst_out !== 1'b1) begin
         cap.delete();
         post_cnt = 0;
      end else if (cap.size() < DEPTH) begin
         cap.push_back(pe_data_out);
         post_cnt = 0;
         if (cap.size() == DEPTH) last_stream = cap;
      end else begin
         post_cnt++;
      end
      if (pe_rst_out === 1'b1 && cap.size() == DEPTH &&
          post_cnt >= DRAIN_LAT && post_cnt < DRAIN_LAT + O_CH)
         pe_psum_in = psum_of(cap, post_cnt - DRAIN_LAT);
      else
         pe_psum_in = WIDTH'($urandom);
   end

   typedef struct {
      int gap;        // 0 gapless, 1 bubble before every word, 2 random bubbles
      int ready_mode; // 1 always ready, 2 random ready
      int stall_row;  // row held with ready low, -1 for none
      int stall_len;
      int glitch;     // pulse start_in during FILL and DRAIN
      int exp_fill;   // expected FILL cycles, -1 = words plus bubbles
   } vec_t;

   vec_t vec[6];

   task automatic do_fill(input int j, input vec_t v, output logic [DATA_W-1:0] words[$]);
      int sent = 0, bubbles = 0, budget = 0, f0;
      bit vld, rdy, last_bub = 0;
      words.delete();
      for (int i = 0; i < DEPTH; i++) words.push_back(DATA_W'($urandom));
      @(posedge clk); #1;
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      f0 = fill_cyc;
      while (sent < DEPTH && budget < 2000) begin
         vld = !((v.gap == 1 && !last_bub) || (v.gap == 2 && $urandom_range(0, 2) == 0));
         last_bub = !vld;
         if (!vld) bubbles++;
         src_valid_in = vld;
         src_data_in  = vld ? words[sent] : DATA_W'($urandom);
         start_in     = (v.glitch != 0) && (sent % 5 == 2);
         @(negedge clk);
         rdy = src_ready_out;
         @(posedge clk); #1;
         if (vld && rdy) sent++;
         budget++;
      end
      src_valid_in = 1'b0;
      start_in = 1'b0;
      check($sformatf("job%0d_fill_words", j), sent, DEPTH);
      check($sformatf("job%0d_fill_cycles", j), fill_cyc - f0,
            (v.exp_fill < 0) ? DEPTH + bubbles : v.exp_fill);
   endtask

   task automatic run_job(input int j, input vec_t v);
      logic [DATA_W-1:0] words[$];
      logic [WIDTH-1:0] exp_ps[O_CH];
      int c0, b0, row = 0, stall = 0, budget = 0, bad = 0;
      bit done_seen = 0;
      c0 = clear_cyc;
      b0 = busy_cyc;
      do_fill(j, v, words);
      for (int r = 0; r < O_CH; r++) exp_ps[r] = psum_of(words, r);
      // Cycle after the last accept: CLEAR with array held clear.
      @(negedge clk);
      check($sformatf("job%0d_ready_drop", j), src_ready_out, 0);
      check($sformatf("job%0d_clear_rst", j), pe_rst_out, 0);
      @(posedge clk); #1;
      psum_ready_in = 1'b1;
      while (!done_seen && budget < 300) begin
         if (psum_valid_out && row == v.stall_row && stall < v.stall_len) begin
            psum_ready_in = 1'b0;
            stall++;
         end else begin
            psum_ready_in = (v.ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         start_in = (v.glitch != 0) && (psum_valid_out || done_out);
         @(negedge clk);
         if (psum_valid_out) begin
            if (row >= O_CH) check($sformatf("job%0d_extra_psum", j), row, O_CH - 1);
            else if (psum_ready_in) begin
               check($sformatf("job%0d_psum_row%0d", j, row), psum_data_out, exp_ps[row]);
               row++;
            end else begin
               check($sformatf("job%0d_psum_hold%0d", j, row), psum_data_out, exp_ps[row]);
            end
         end
         if (done_out) begin
            done_seen = 1;
            check($sformatf("job%0d_done_after_last", j), row, O_CH);
         end
         @(posedge clk); #1;
         budget++;
      end
      start_in = 1'b0;
      psum_ready_in = 1'b1;
      check($sformatf("job%0d_done_seen", j), done_seen, 1);
      check($sformatf("job%0d_stall_cycles", j), stall, (v.stall_row >= 0) ? v.stall_len : 0);
      @(negedge clk);
      check($sformatf("job%0d_done_pulse", j), done_out, 0);
      check($sformatf("job%0d_idle_after", j), busy_out, 0);
      check($sformatf("job%0d_clear_cycles", j), clear_cyc - c0, 1);
      for (int i = 0; i < DEPTH; i++)
         if (i >= last_stream.size() || last_stream[i] !== words[i]) bad++;
      check($sformatf("job%0d_stream_words_bad", j), bad, 0);
`ifdef PE_SEQ_PERF_EN
      check($sformatf("job%0d_perf", j), perf_cycles_out, busy_cyc - b0);
      if (v.gap == 0 && v.ready_mode == 1 && v.stall_row < 0)
         check($sformatf("job%0d_perf_gapless", j), perf_cycles_out,
               DEPTH + 1 + DEPTH + (DRAIN_LAT - 1) + O_CH + O_CH);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] scratch[$];
      int budget;
      vec[0] = '{0, 1, -1, 0, 0, DEPTH};
      vec[1] = '{1, 1, -1, 0, 0, 2 * DEPTH};
      vec[2] = '{0, 1,  1, 5, 0, DEPTH};
      vec[3] = '{0, 1, -1, 0, 1, DEPTH};
      vec[4] = '{2, 2, -1, 0, 0, -1};
      vec[5] = '{2, 2,  2, 3, 1, -1};

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_src_ready", src_ready_out, 0);
      check("rst_pe_data", pe_data_out, 0);
      check("rst_pe_rst", pe_rst_out, 0);
      check("rst_psum_valid", psum_valid_out, 0);
      check("rst_psum_data", psum_data_out, 0);
`ifdef PE_SEQ_PERF_EN
      check("rst_perf", perf_cycles_out, 0);
`endif
      @(posedge clk); #1;
      rst_in = 1'b0;

      for (int j = 0; j < 6; j++) run_job(j, vec[j]);

      // Reset while word 10 is on pe_data_out, then replay a full job.
      do_fill(10, vec[0], scratch);
      budget = 0;
      while (cap.size() < 10 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("midrst_reached_word10", cap.size(), 10);
      @(posedge clk); #1;
      rst_in = 1'b1;
      @(posedge clk); #1;
      rst_in = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy_out, 0);
      check("midrst_pe_rst", pe_rst_out, 0);
      check("midrst_pe_data", pe_data_out, 0);
      check("midrst_src_ready", src_ready_out, 0);
      check("midrst_psum_valid", psum_valid_out, 0);
      repeat (2) @(negedge clk);
      check("midrst_stays_idle", busy_out, 0);
      run_job(11, vec[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_array_seq.md
Name: pe_array_seq

Overview:
- Job sequencer in front of PE_array.
- Buffers one complete job of interleaved weight/activation words from an upstream valid/ready stream.
- Clears the array, then streams the words gaplessly into PE_array data_in.
- Captures the O_CH partial sums and hands them downstream over valid/ready.
- Exists because PE_array has no stall or enable: its input stream must be continuous, so the sequencer absorbs upstream bubbles and downstream backpressure.

Parameters:
- ROW_LENGTH, 7, PE row length
- O_CH, 3, number of PE rows (output channels)
- K, 1, runs per job
- WIDTH, 14, psum bit width
- DATA_W, 27, PE data word width
- DRAIN_LAT, 3, cycles from the last streamed word to the first valid psum
- DEPTH, (O_CH+1)*ROW_LENGTH*K, words per job (derived; not to be overridden)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  start a job (sampled in IDLE only)
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  one-cycle pulse when the last psum is accepted downstream
- src_valid_in  in  1  upstream word valid
- src_data_in  in  DATA_W  upstream word (weights and activations interleaved, PE order)
- src_ready_out  out  1  high only in FILL
- pe_data_out  out  DATA_W  to PE_array data_in, registered
- pe_rst_out  out  1  to PE_array rst_in; 0 = array held clear
- pe_psum_in  in  WIDTH  from PE_array psum_out
- psum_valid_out  out  1  result valid
- psum_data_out  out  WIDTH  result, row 0 first
- psum_ready_in  in  1  downstream ready

Behaviour:
- Reset values: busy_out 0, done_out 0, src_ready_out 0, pe_data_out 0, pe_rst_out 0, psum_valid_out 0, psum_data_out 0. All counters 0, FSM in IDLE.
- rst_in asserted in any state, including mid-STREAM: next cycle all outputs at reset values and FSM in IDLE. Partial buffer and result contents are discarded.
- FSM states: IDLE, FILL, CLEAR, STREAM, WAIT, COLLECT, DRAIN.
- IDLE: start_in=1 -> FILL, wr_ptr=0. start_in is ignored in every other state.
- FILL: src_ready_out=1. Each cycle with src_valid_in && src_ready_out writes buf[wr_ptr] and increments wr_ptr. The accept of word DEPTH-1 goes to CLEAR; src_ready_out is 0 the following cycle. Upstream bubbles are tolerated without limit.
- CLEAR: pe_rst_out=0 for exactly 1 cycle, then STREAM with rd_ptr=0.
- STREAM:
  - pe_rst_out=1 from here until return to IDLE.
  - pe_data_out = buf[rd_ptr] on DEPTH consecutive cycles, no gaps.
  - After the last word, pe_data_out holds the last word; go to WAIT.
- WAIT: DRAIN_LAT-1 cycles, then COLLECT.
- Timing: if the last word is driven in cycle T, row r psum is sampled from pe_psum_in at the end of cycle T+DRAIN_LAT+r, for r=0..O_CH-1.
- COLLECT: O_CH consecutive cycles, capture pe_psum_in into res[r]. Unconditional, because PE_array cannot stall. Then DRAIN.
- DRAIN:
  - psum_valid_out=1, psum_data_out=res[idx].
  - idx advances only on psum_valid_out && psum_ready_in.
  - Data is stable while valid is high and ready is low.
  - After the accept of idx=O_CH-1: psum_valid_out=0, done_out=1 for one cycle, then IDLE.
- Widths: all pointers ceil(log2(DEPTH)); idx ceil(log2(O_CH)). No pointer wrap occurs within a job. Pointers reset to 0 on entering FILL/STREAM/DRAIN.
- Back-to-back jobs: start_in held high in the done_out cycle is not seen. It is sampled in the following IDLE cycle.

Optional Feature:
- Macro: PE_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles_out [15:0], counting cycles with busy_out=1.
  - Cleared on entering FILL; saturates at 16'hFFFF; holds in IDLE; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package pe_array_pkg holds:
  - default constants ROW_LENGTH, O_CH, K, WIDTH, DATA_W, DRAIN_LAT
  - the state enum
  - a DEPTH calculation function
- Sub-module seq_job_buf: DEPTH x DATA_W single-write, single-read register buffer with write enable and read address. Used by FILL and STREAM.

Test Plan:
- Reset then start_in=1 with 28 gapless words from the PE_array golden data set -> pe_rst_out=0 for 1 cycle, then 28 contiguous pe_data_out words in order. With the PE_array model attached, psum outputs equal the 3 golden values, and done_out pulses after the third accept.
- Same job with src_valid_in toggling 1/0 every cycle -> 56-cycle FILL, but the STREAM phase is still 28 contiguous cycles and the psums are identical.
- psum_ready_in low for 5 cycles at row 1 -> psum_data_out holds res[1] with valid=1 throughout, no row skipped, done_out only after row 2 is accepted.
- rst_in asserted at STREAM word 10 -> next cycle busy_out=0 and pe_rst_out=0. A new start replays the full job correctly.
- start_in pulsed during FILL and during DRAIN -> ignored; word count stays 28 and exactly one done_out per job.
- With PE_SEQ_PERF_EN: gapless job with psum_ready_in=1 -> perf_cycles_out = 28 FILL + 1 CLEAR + 28 STREAM + 2 WAIT + 3 COLLECT + 3 DRAIN = 65.
